alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational `alu` instance among `REQ` independent requesters. It accepts one operation per grant over a valid/ready handshake and drives the shared ALU's operand, opcode and select inputs for one execute cycle. It captures the result and flags into registers and returns them with the requester ID over a valid/ready response channel. It sits between the requesting engines and the `alu` datapath; the `alu` instance lives outside this block.

## Interface
Parameters:
- `N`, default 8: operand width; must match the attached `alu`.
- `REQ`, default 4: number of requesters, 2..16.
- `IDW`, default 2: requester ID width; must equal clog2(`REQ`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  REQ  per-requester request valid.
- `req_ready`  out  REQ  per-requester accept, one-hot or zero.
- `req_a`, `req_b`  in  REQ*N each  operands; requester i uses slice [i*N +: N].
- `req_opcode`  in  REQ*4  opcodes; requester i uses slice [i*4 +: 4].
- `req_sel`  in  REQ*3  select field; requester i uses slice [i*3 +: 3].
- `alu_a`, `alu_b`  out  N each  operands driven to the shared `alu`.
- `alu_opcode`  out  4  opcode driven to the shared `alu`.
- `alu_sel`  out  3  select driven to the shared `alu`.
- `alu_result`  in  N  `alu` result output.
- `alu_mult_result`  in  2N  `alu` multiply output.
- `alu_zero`, `alu_carry`, `alu_overflow`, `alu_sign`  in  1 each  `alu` flag outputs.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted by the consumer.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  N  captured result.
- `rsp_mult_result`  out  2N  captured multiply result.
- `rsp_zero`, `rsp_carry`, `rsp_overflow`, `rsp_sign`  out  1 each  captured flags.
- `rsp_err`  out  1  set when the opcode was unsupported.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first `i` with `req_valid[i]`, searching from `ptr`, then `ptr+1`, and so on, wrapping at `REQ`.
  - `req_ready[winner]` = 1 combinationally; all other bits 0.
  - On that edge, latch the winner's operands, opcode, sel and ID, and set `ptr` = (winner+1) mod `REQ`.
  - Next state is EXEC for a supported opcode and RESP for an unsupported one.
  - With no request pending, stay in IDLE; `ptr` is unchanged.
- Supported opcodes: 0000–0110 and 1001.
  - Unsupported opcodes (0111, 1000, 1010–1111) never reach the ALU.
  - For these, capture `rsp_err`=1, all results 0 and all flags 0.
- EXEC:
  - `alu_*` are driven from the latched registers.
  - At the end of the cycle, capture the response registers, then go to RESP.
  - Opcodes 0000–0110: `rsp_result`=`alu_result`, `rsp_mult_result`=0, flags taken from the `alu_*` flag inputs.
  - Opcode 1001: `rsp_mult_result`=`alu_mult_result` and `rsp_result`=0.
    - For 1001 the controller computes the flags itself: `rsp_zero` = (`alu_mult_result`==0), `rsp_sign` = `alu_mult_result[2N-1]`, `rsp_carry` = `rsp_overflow` = 0.
    - The `alu` flags are ignored because they are stale for this opcode.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` are held stable.
  - All `req_ready` bits are 0.
  - When `rsp_valid && rsp_ready`, go to IDLE.
- `alu_*` outputs hold their last value outside EXEC; the capture registers are written only in EXEC.

## Timing
- Reset (async assert, sync release): state=IDLE, `ptr`=0, and every output is 0. That includes `req_ready`, `rsp_*`, `alu_*` and `busy`.
- A `rst_n` assertion in any state aborts the in-flight operation. No response is ever produced for it.
- Supported op accepted at edge t:
  - EXEC runs in cycle t+1.
  - `rsp_valid` is high from cycle t+2.
- Unsupported op accepted at edge t: `rsp_valid` is high from cycle t+1.
- With `rsp_ready` held at 1:
  - Supported ops issue at most once every 3 cycles.
  - Unsupported ops issue at most once every 2 cycles.
- A requester must hold `req_valid` and its fields stable until it sees `req_ready`. Dropping `req_valid` earlier withdraws the request with no effect.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely. No grants are issued while in RESP.
- Requests that arrive while the FSM is outside IDLE wait. They are arbitrated at the next IDLE cycle from the current `ptr`.

## Test plan
1. Requester 0 alone (N=8): A=8'h0F, B=8'h01, opcode 0000, accepted at edge t -> `rsp_valid` high at t+2 with `rsp_id`=0, `rsp_result`=8'h10, `rsp_zero`=0, `rsp_sign`=0, `rsp_err`=0.
2. All four requesters valid from reset, `rsp_ready`=1 -> grant order 0,1,2,3,0; each grant is 3 cycles apart; `ptr` wraps to 0.
3. Requester 2: A=8'hFF, B=8'h02, opcode 1001 -> `rsp_mult_result`=16'h01FE, `rsp_result`=8'h00, `rsp_zero`=0, `rsp_sign`=0; then A=8'h00 -> `rsp_zero`=1.
4. Requester 1: opcode 1010 -> `rsp_err`=1 at t+1, result 0, `alu_opcode` not changed.
5. `rsp_ready`=0 for 5 cycles with other requesters valid -> response fields stable, `req_ready`=0, no grant until the handshake; the next grant goes to the next index after the previous winner.
6. `rst_n` pulled low during EXEC -> all outputs 0 immediately; after release, no response appears and the first grant goes to the lowest valid index (`ptr`=0).

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of request, shared-ALU and response signals around alu_arbiter.
// slave is the arbiter side; master is the requesters/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int N   = 8,
    parameter int REQ = 4,
    parameter int IDW = 2
);
    logic [REQ-1:0]   req_valid;
    logic [REQ-1:0]   req_ready;
    logic [REQ*N-1:0] req_a;
    logic [REQ*N-1:0] req_b;
    logic [REQ*4-1:0] req_opcode;
    logic [REQ*3-1:0] req_sel;

    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_opcode;
    logic [2:0]       alu_sel;
    logic [N-1:0]     alu_result;
    logic [2*N-1:0]   alu_mult_result;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_sign;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [N-1:0]     rsp_result;
    logic [2*N-1:0]   rsp_mult_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_sign;
    logic             rsp_err;

    logic             busy;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, req_sel,
        input  alu_result, alu_mult_result, alu_zero, alu_carry, alu_overflow, alu_sign,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_opcode, alu_sel,
        output rsp_valid, rsp_id, rsp_result, rsp_mult_result,
        output rsp_zero, rsp_carry, rsp_overflow, rsp_sign, rsp_err,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode, req_sel,
        output alu_result, alu_mult_result, alu_zero, alu_carry, alu_overflow, alu_sign,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_opcode, alu_sel,
        input  rsp_valid, rsp_id, rsp_result, rsp_mult_result,
        input  rsp_zero, rsp_carry, rsp_overflow, rsp_sign, rsp_err,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among REQ requesters.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate from ptr, grant one requester, latch its operation
// EXEC    | drive latched operation into the ALU, capture result at end
// RESP    | hold response valid until the consumer accepts it
module alu_arbiter #(
    parameter int N   = 8,
    parameter int REQ = 4,
    parameter int IDW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b1001;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx_w;
    int             idx;

    logic [N-1:0]   win_a;
    logic [N-1:0]   win_b;
    logic [3:0]     win_op;
    logic [2:0]     win_sel;

    logic [N-1:0]   alu_a_q;
    logic [N-1:0]   alu_b_q;
    logic [3:0]     alu_op_q;
    logic [2:0]     alu_sel_q;

    logic [IDW-1:0] rsp_id_q;
    logic [N-1:0]   rsp_result_q;
    logic [2*N-1:0] rsp_mult_q;
    logic           rsp_zero_q;
    logic           rsp_carry_q;
    logic           rsp_overflow_q;
    logic           rsp_sign_q;
    logic           rsp_err_q;

    function automatic logic op_supported(input logic [3:0] op);
        return (op <= 4'd6) || (op == OP_MUL);
    endfunction

    // Rotating priority search starting at ptr, wrapping at REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQ) begin
                idx = idx - REQ;
            end
            idx_w = idx[IDW-1:0];
            if (!found && bus.req_valid[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_op  = '0;
        win_sel = '0;
        for (int k = 0; k < REQ; k++) begin
            if (win == IDW'(k)) begin
                win_a   = bus.req_a[k*N +: N];
                win_b   = bus.req_b[k*N +: N];
                win_op  = bus.req_opcode[k*4 +: 4];
                win_sel = bus.req_sel[k*3 +: 3];
            end
        end
    end

    // Gated by rst_n so req_ready is zero while reset is held, not just after it.
    assign bus.req_ready = (state == ST_IDLE && found && rst_n) ? (REQ'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            alu_sel_q      <= '0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_mult_q     <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_sign_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        ptr      <= (win == IDW'(REQ - 1)) ? '0 : win + 1'b1;
                        rsp_id_q <= win;
                        if (op_supported(win_op)) begin
                            alu_a_q   <= win_a;
                            alu_b_q   <= win_b;
                            alu_op_q  <= win_op;
                            alu_sel_q <= win_sel;
                            state     <= ST_EXEC;
                        end else begin
                            // Unsupported op bypasses the ALU entirely.
                            rsp_result_q   <= '0;
                            rsp_mult_q     <= '0;
                            rsp_zero_q     <= 1'b0;
                            rsp_carry_q    <= 1'b0;
                            rsp_overflow_q <= 1'b0;
                            rsp_sign_q     <= 1'b0;
                            rsp_err_q      <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_err_q <= 1'b0;
                    if (alu_op_q == OP_MUL) begin
                        // ALU flags are stale for multiply; derive them from the product.
                        rsp_result_q   <= '0;
                        rsp_mult_q     <= bus.alu_mult_result;
                        rsp_zero_q     <= (bus.alu_mult_result == '0);
                        rsp_carry_q    <= 1'b0;
                        rsp_overflow_q <= 1'b0;
                        rsp_sign_q     <= bus.alu_mult_result[2*N-1];
                    end else begin
                        rsp_result_q   <= bus.alu_result;
                        rsp_mult_q     <= '0;
                        rsp_zero_q     <= bus.alu_zero;
                        rsp_carry_q    <= bus.alu_carry;
                        rsp_overflow_q <= bus.alu_overflow;
                        rsp_sign_q     <= bus.alu_sign;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.alu_a           = alu_a_q;
    assign bus.alu_b           = alu_b_q;
    assign bus.alu_opcode      = alu_op_q;
    assign bus.alu_sel         = alu_sel_q;

    assign bus.rsp_valid       = (state == ST_RESP);
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_mult_result = rsp_mult_q;
    assign bus.rsp_zero        = rsp_zero_q;
    assign bus.rsp_carry       = rsp_carry_q;
    assign bus.rsp_overflow    = rsp_overflow_q;
    assign bus.rsp_sign        = rsp_sign_q;
    assign bus.rsp_err         = rsp_err_q;

    assign bus.busy            = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU, transaction-level reference model, directed and random stimulus.
module tb_alu_arbiter;
    localparam int N   = 8;
    localparam int REQ = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N), .REQ(REQ), .IDW(IDW)) bus ();

    alu_arbiter #(.N(N), .REQ(REQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] r;
        logic z, c, o, s;
    } alu_out_t;

    typedef struct {
        int             id;
        logic [N-1:0]   r;
        logic [2*N-1:0] m;
        logic           z, c, o, s, e;
    } rec_t;

    function automatic logic is_sup(input logic [3:0] op);
        return (op <= 4'd6) || (op == 4'd9);
    endfunction

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    // Stand-in for the external ALU; multiply flags are deliberately wrong.
    function automatic alu_out_t stub(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic [3:0] op, input logic [2:0] sel);
        logic [N:0] w;
        alu_out_t t;
        case (op)
            4'd0: w = {1'b0, a} + {1'b0, b};
            4'd1: w = {1'b0, a} - {1'b0, b};
            4'd2: w = {1'b0, a & b};
            4'd3: w = {1'b0, a | b};
            4'd4: w = {1'b0, a ^ b};
            4'd5: w = {1'b0, a << sel};
            4'd6: w = {1'b0, a >> sel};
            default: w = {1'b0, ~a};
        endcase
        t.r = w[N-1:0];
        t.c = w[N];
        t.o = (op == 4'd0) ? (a[N-1] == b[N-1] && t.r[N-1] != a[N-1]) :
              (op == 4'd1) ? (a[N-1] != b[N-1] && t.r[N-1] != a[N-1]) : 1'b0;
        t.z = (t.r == '0);
        t.s = t.r[N-1];
        if (op == 4'd9) begin
            t.z = (prod(a, b) != '0);
            t.c = 1'b1;
            t.o = 1'b1;
            t.s = ~prod(a, b)[2*N-1];
        end
        return t;
    endfunction

    function automatic rec_t ref_rsp(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic [3:0] op, input logic [2:0] sel);
        rec_t r;
        alu_out_t t;
        r.id = id; r.r = '0; r.m = '0; r.z = 0; r.c = 0; r.o = 0; r.s = 0; r.e = 0;
        if (!is_sup(op)) begin
            r.e = 1'b1;
        end else if (op == 4'd9) begin
            r.m = prod(a, b);
            r.z = (r.m == '0);
            r.s = r.m[2*N-1];
        end else begin
            t = stub(a, b, op, sel);
            r.r = t.r; r.z = t.z; r.c = t.c; r.o = t.o; r.s = t.s;
        end
        return r;
    endfunction

    alu_out_t alu_now;
    always_comb begin
        alu_now              = stub(bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_sel);
        bus.alu_result       = alu_now.r;
        bus.alu_zero         = alu_now.z;
        bus.alu_carry        = alu_now.c;
        bus.alu_overflow     = alu_now.o;
        bus.alu_sign         = alu_now.s;
        bus.alu_mult_result  = prod(bus.alu_a, bus.alu_b);
    end

    // Reference model: one pending operation (executing or awaiting hand-off) at a time.
    logic [REQ-1:0]       g_vec = '0;
    int                   m_ptr = 0;
    bit                   m_exec = 0;
    bit                   m_resp = 0;
    rec_t                 m_rec;
    logic [2*N+6:0]       m_alu = '0;

    always @(negedge clk) begin
        logic [REQ-1:0] exp_ready;
        int win, idx;
        logic [N-1:0] wa, wb;
        logic [3:0]   wop;
        logic [2:0]   wsel;
        if (!rst_n) begin
            chk("reset_outputs",
                {bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result,
                 bus.rsp_mult_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow,
                 bus.rsp_sign, bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_sel},
                64'd0);
            m_ptr = 0; m_exec = 0; m_resp = 0; m_alu = '0; g_vec = '0;
        end else begin
            win = -1;
            exp_ready = '0;
            if (!m_exec && !m_resp) begin
                for (int k = 0; k < REQ; k++) begin
                    idx = (m_ptr + k) % REQ;
                    if (win < 0 && bus.req_valid[idx]) win = idx;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", bus.busy, m_exec || m_resp);
            chk("rsp_valid", bus.rsp_valid, m_resp);
            chk("alu_inputs", {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_sel}, m_alu);
            if (m_resp) begin
                chk("rsp_id", bus.rsp_id, m_rec.id);
                chk("rsp_result", bus.rsp_result, m_rec.r);
                chk("rsp_mult_result", bus.rsp_mult_result, m_rec.m);
                chk("rsp_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_sign},
                    {m_rec.z, m_rec.c, m_rec.o, m_rec.s});
                chk("rsp_err", bus.rsp_err, m_rec.e);
            end
            g_vec = exp_ready;
            if (m_resp && bus.rsp_ready) m_resp = 0;
            if (m_exec) begin
                m_exec = 0;
                m_resp = 1;
            end
            if (win >= 0) begin
                wa   = bus.req_a[win*N +: N];
                wb   = bus.req_b[win*N +: N];
                wop  = bus.req_opcode[win*4 +: 4];
                wsel = bus.req_sel[win*3 +: 3];
                m_ptr = (win + 1) % REQ;
                m_rec = ref_rsp(win, wa, wb, wop, wsel);
                if (is_sup(wop)) begin
                    m_exec = 1;
                    m_alu  = {wa, wb, wop, wsel};
                end else begin
                    m_resp = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~g_vec;
    endtask

    task automatic issue(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] op, input logic [2:0] sel);
        bus.req_a[i*N +: N]    = a;
        bus.req_b[i*N +: N]    = b;
        bus.req_opcode[i*4 +: 4] = op;
        bus.req_sel[i*3 +: 3]  = sel;
        bus.req_valid[i]       = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid || n >= 20) break;
            tick();
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        bus.req_valid = '0;
        do begin
            tick();
            c++;
        end while (bus.busy && c < 50);
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] t;
        if ($urandom_range(0, 4) == 0) begin
            do t = 4'($urandom); while (is_sup(t));
        end else begin
            t = 4'($urandom_range(0, 7));
            if (t == 4'd7) t = 4'd9;
        end
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ng, cyc, id;
        int gid[5];
        int gcyc[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_opcode = '0; bus.req_sel = '0; bus.rsp_ready = 1'b1;

        // All four requesters valid out of reset.
        for (int i = 0; i < REQ; i++) issue(i, N'(i + 1), 8'h02, 4'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (g_vec != '0) begin
                id = 0;
                for (int i = 0; i < REQ; i++) if (g_vec[i]) id = i;
                gid[ng] = id; gcyc[ng] = cyc; ng++;
                if (id == 0) issue(0, 8'h11, 8'h22, 4'd0, 3'd0);
            end
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) if (k < ng) chk("rr_order", gid[k], exp_order[k]);
        for (int k = 1; k < 5; k++) if (k < ng) chk("rr_spacing", gcyc[k] - gcyc[k-1], 3);

        // Requester 0 alone: 0x0F + 0x01.
        wait_idle();
        issue(0, 8'h0F, 8'h01, 4'd0, 3'd0);
        wait_rsp(n);
        chk("add_latency", n, 3);
        chk("add_id", bus.rsp_id, 0);
        chk("add_result", bus.rsp_result, 8'h10);
        chk("add_zero_sign", {bus.rsp_zero, bus.rsp_sign}, 2'b00);
        chk("add_err", bus.rsp_err, 0);

        // Multiply on requester 2, non-zero then zero product.
        wait_idle();
        issue(2, 8'hFF, 8'h02, 4'b1001, 3'd0);
        wait_rsp(n);
        chk("mul_latency", n, 3);
        chk("mul_id", bus.rsp_id, 2);
        chk("mul_product", bus.rsp_mult_result, 16'h01FE);
        chk("mul_result", bus.rsp_result, 8'h00);
        chk("mul_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_sign}, 4'b0000);
        wait_idle();
        issue(2, 8'h00, 8'h02, 4'b1001, 3'd0);
        wait_rsp(n);
        chk("mul_zero_product", bus.rsp_mult_result, 16'h0000);
        chk("mul_zero_flag", bus.rsp_zero, 1);

        // Unsupported opcode on requester 1.
        wait_idle();
        issue(1, 8'h33, 8'h44, 4'b1010, 3'd5);
        wait_rsp(n);
        chk("err_latency", n, 2);
        chk("err_flag", bus.rsp_err, 1);
        chk("err_id", bus.rsp_id, 1);
        chk("err_results", {bus.rsp_result, bus.rsp_mult_result}, 0);
        chk("err_alu_opcode_kept", bus.alu_opcode, 4'b1001);

        // Backpressure with other requesters waiting.
        wait_idle();
        bus.rsp_ready = 1'b0;
        issue(0, 8'h05, 8'h06, 4'd0, 3'd0);
        wait_rsp(n);
        issue(1, 8'h07, 8'h01, 4'd1, 3'd0);
        issue(3, 8'h09, 8'h03, 4'd2, 3'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("bp_result_hold", bus.rsp_result, 8'h0B);
            chk("bp_id_hold", bus.rsp_id, 0);
            chk("bp_no_ready", bus.req_ready, 0);
            chk("bp_valid_hold", bus.rsp_valid, 1);
        end
        tick();
        bus.rsp_ready = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (g_vec == '0 && cyc < 10);
        chk("bp_next_grant", g_vec, 4'b0010);

        // Reset asserted while an operation is executing.
        wait_idle();
        issue(1, 8'h03, 8'h04, 4'd0, 3'd0);
        tick();
        chk("abort_grant", g_vec, 4'b0010);
        chk("abort_in_exec", {bus.busy, bus.rsp_valid}, 2'b10);
        rst_n = 1'b0;
        issue(0, 8'h01, 8'h01, 4'd0, 3'd0);
        issue(2, 8'h02, 8'h02, 4'd0, 3'd0);
        #1;
        chk("abort_outputs_zero", {bus.busy, bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_opcode}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (g_vec == '0 && cyc < 10);
        chk("abort_first_grant", g_vec, 4'b0001);

        // Randomized traffic with random backpressure and withdrawals.
        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            tick();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < REQ; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        issue(i, N'($urandom), N'($urandom), rand_op(), 3'($urandom));
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.rsp_ready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
